pingpong_obuf: RTL and testbench

//   Parametrised double-buffered (ping-pong) output buffer between the PPU write stream and a

---
 rtl/obuf_pkg.sv | 16 +
 rtl/obuf_bank.sv | 24 ++
 rtl/pingpong_obuf.sv | 138 +++++++++++++
 tb/tb_pingpong_obuf.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/obuf_pkg.sv
// Shared types and default sizing for the ping-pong output buffer.
package obuf_pkg;

  localparam int ELEM_W_DEF   = 4;
  localparam int NUM_ELEM_DEF = 16;
  localparam int DEPTH_DEF    = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_VALID = 2'd2
  } rd_state_t;

  typedef logic bank_idx_t;

endpackage

// File: rtl/obuf_bank.sv
// Simple dual-port synchronous RAM: one write port, one read port, 1-cycle read latency.
module obuf_bank #(
  parameter int WORD_W = 64,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH];

  // rdata only moves on re, so it holds the last beat while the consumer stalls.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/pingpong_obuf.sv
// Double-buffered output buffer: the PPU fills one bank per tile while the other bank
// drains over a valid/ready port, one beat every two cycles.
module pingpong_obuf
  import obuf_pkg::*;
#(
  parameter int ELEM_W   = ELEM_W_DEF,
  parameter int NUM_ELEM = NUM_ELEM_DEF,
  parameter int DEPTH    = DEPTH_DEF,
  parameter int ADDR_W   = $clog2(DEPTH),
  localparam int WORD_W  = ELEM_W * NUM_ELEM
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_flush,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [WORD_W-1:0] i_wdata,
  input  logic              i_wlast,
  output logic              o_wfull,
  output logic              o_overflow,
  output logic [1:0]        o_bank_full,
  output logic              o_rd_valid,
  input  logic              i_rd_ready,
  output logic [WORD_W-1:0] o_rd_data,
  output logic [ADDR_W-1:0] o_rd_addr,
  output logic              o_rd_bank,
  output logic              o_rd_last,
  output logic [1:0]        o_rd_state
);

  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_W   = (ADDR_W+1)'(1);

  rd_state_t               state, state_nxt;
  bank_idx_t               wr_sel, rd_sel;
  logic [1:0]              bank_full;
  logic [1:0][ADDR_W:0]    len_q;
  logic [ADDR_W:0]         rd_ptr;
  logic                    overflow_q;
  logic                    out_last;
  logic                    bank_re;
  logic                    rd_valid;
  logic [WORD_W-1:0]       bank_rdata [2];

  logic wr_accept, wr_commit, rd_fire, rd_at_end, rd_end;
  logic [1:0] set_mask, clr_mask;

  assign wr_accept = i_we && !bank_full[wr_sel] && ({1'b0, i_waddr} < DEPTH_W);
  assign wr_commit = wr_accept && i_wlast;
  assign rd_fire   = rd_valid && i_rd_ready;
  assign rd_at_end = (rd_ptr == len_q[rd_sel] - ONE_W);
  assign rd_end    = rd_fire && rd_at_end;
  assign set_mask  = 2'(wr_commit) << wr_sel;
  assign clr_mask  = 2'(rd_end) << rd_sel;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    obuf_bank #(.WORD_W(WORD_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_bank (
      .clk   (i_clk),
      .we    (wr_accept && (wr_sel == 1'(b))),
      .waddr (i_waddr),
      .wdata (i_wdata),
      .re    (bank_re && (rd_sel == 1'(b))),
      .raddr (rd_ptr[ADDR_W-1:0]),
      .rdata (bank_rdata[b])
    );
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)        state <= ST_IDLE;
    else if (i_flush) state <= ST_IDLE;
    else              state <= state_nxt;
  end

  // A beat transfers on any edge where o_rd_valid && i_rd_ready; while valid is high and
  // ready is low, data/addr/last/bank are held unchanged and valid stays asserted.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (bank_full[rd_sel]) state_nxt = ST_ISSUE;
      ST_ISSUE: state_nxt = ST_VALID;
      ST_VALID: if (i_rd_ready) state_nxt = rd_at_end ? ST_IDLE : ST_ISSUE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    rd_valid = (state == ST_VALID);
    bank_re  = (state == ST_ISSUE);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_sel     <= 1'b0;
      rd_sel     <= 1'b0;
      bank_full  <= 2'b00;
      len_q      <= '0;
      rd_ptr     <= '0;
      overflow_q <= 1'b0;
      out_last   <= 1'b0;
    end else if (i_flush) begin
      wr_sel     <= 1'b0;
      rd_sel     <= 1'b0;
      bank_full  <= 2'b00;
      len_q      <= '0;
      rd_ptr     <= '0;
      overflow_q <= 1'b0;
      out_last   <= 1'b0;
    end else begin
      // Commit and release always hit different banks, so both masks apply together.
      bank_full <= (bank_full | set_mask) & ~clr_mask;
      if (wr_commit) begin
        len_q[wr_sel] <= {1'b0, i_waddr} + ONE_W;
        wr_sel        <= ~wr_sel;
      end
      if (i_we && !wr_accept) overflow_q <= 1'b1;
      if (bank_re) out_last <= rd_at_end;
      if (rd_fire) begin
        if (rd_at_end) begin
          rd_ptr <= '0;
          rd_sel <= ~rd_sel;
        end else begin
          rd_ptr <= rd_ptr + ONE_W;
        end
      end
    end
  end

  assign o_wfull     = bank_full[wr_sel];
  assign o_overflow  = overflow_q;
  assign o_bank_full = bank_full;
  assign o_rd_valid  = rd_valid;
  assign o_rd_data   = rd_valid ? bank_rdata[rd_sel] : '0;
  assign o_rd_addr   = rd_valid ? rd_ptr[ADDR_W-1:0] : '0;
  assign o_rd_last   = rd_valid & out_last;
  assign o_rd_bank   = rd_sel;
  assign o_rd_state  = state;

endmodule

// File: tb/tb_pingpong_obuf.sv
// Bench for pingpong_obuf: tile-level reference model feeding a scoreboard queue of expected beats.
module tb_pingpong_obuf;

  localparam int ELEM_W   = 4;
  localparam int NUM_ELEM = 16;
  localparam int WORD_W   = ELEM_W * NUM_ELEM;
  localparam int DEPTH    = 64;
  localparam int ADDR_W   = 6;
  localparam int EW       = 1 + ADDR_W + 1 + WORD_W;

  logic              i_clk, i_rst, i_flush, i_we, i_wlast, i_rd_ready;
  logic [ADDR_W-1:0] i_waddr;
  logic [WORD_W-1:0] i_wdata;
  logic              o_wfull, o_overflow, o_rd_valid, o_rd_bank, o_rd_last;
  logic [1:0]        o_bank_full, o_rd_state;
  logic [WORD_W-1:0] o_rd_data;
  logic [ADDR_W-1:0] o_rd_addr;

  pingpong_obuf #(.ELEM_W(ELEM_W), .NUM_ELEM(NUM_ELEM), .DEPTH(DEPTH)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_flush(i_flush), .i_we(i_we), .i_waddr(i_waddr),
    .i_wdata(i_wdata), .i_wlast(i_wlast), .o_wfull(o_wfull), .o_overflow(o_overflow),
    .o_bank_full(o_bank_full), .o_rd_valid(o_rd_valid), .i_rd_ready(i_rd_ready),
    .o_rd_data(o_rd_data), .o_rd_addr(o_rd_addr), .o_rd_bank(o_rd_bank),
    .o_rd_last(o_rd_last), .o_rd_state(o_rd_state)
  );

  // clock / reset
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  int n_checks = 0;
  int n_fail   = 0;
  int beats_seen = 0;
  int rd_mode = 0;

  logic [EW-1:0]     exp_q[$];
  logic [WORD_W-1:0] mem_m [2][DEPTH];
  logic [1:0]        full_m;
  logic              wsel_m;
  logic              ovf_m;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    full_m = 2'b00;
    wsel_m = 1'b0;
    ovf_m  = 1'b0;
    exp_q.delete();
  endfunction

  function automatic logic [WORD_W-1:0] pat(input int a);
    logic [3:0] n;
    n = a[3:0];
    return {NUM_ELEM{n}};
  endfunction

  function automatic logic [WORD_W-1:0] rnd_word();
    return {$urandom, $urandom};
  endfunction

  // Reference model + monitor, sampled late in the low phase, clear of every drive point.
  initial begin
    logic [EW-1:0] e;
    logic [ADDR_W-1:0] av;
    model_reset();
    forever begin
      @(negedge i_clk);
      #2;
      if (i_rst) begin
        model_reset();
        continue;
      end
      chk("wfull", o_wfull, full_m[wsel_m]);
      chk("bank_full", o_bank_full, full_m);
      chk("overflow", o_overflow, ovf_m);
      if (o_rd_valid) begin
        if (exp_q.size() == 0) begin
          chk("extra_beat", 1, 0);
        end else begin
          e = exp_q[0];
          chk("rd_bank", o_rd_bank, e[EW-1]);
          chk("rd_addr", o_rd_addr, e[EW-2 -: ADDR_W]);
          chk("rd_last", o_rd_last, e[WORD_W]);
          chk("rd_data", o_rd_data, e[WORD_W-1:0]);
        end
      end
      if (i_we && !i_flush) begin
        if (full_m[wsel_m]) begin
          ovf_m = 1'b1;
        end else begin
          mem_m[wsel_m][i_waddr] = i_wdata;
          if (i_wlast) begin
            for (int a = 0; a <= int'(i_waddr); a++) begin
              av = ADDR_W'(a);
              exp_q.push_back({wsel_m, av, (a == int'(i_waddr)), mem_m[wsel_m][a]});
            end
            full_m[wsel_m] = 1'b1;
            wsel_m = ~wsel_m;
          end
        end
      end
      if (o_rd_valid && i_rd_ready && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        beats_seen++;
        if (e[WORD_W]) full_m[e[EW-1]] = 1'b0;
      end
      if (i_flush) model_reset();
    end
  end

  // consumer ready pattern: 0 low, 1 high, 2 toggle, 3 random
  initial begin
    i_rd_ready = 1'b0;
    forever begin
      @(posedge i_clk);
      #1;
      case (rd_mode)
        0:       i_rd_ready = 1'b0;
        1:       i_rd_ready = 1'b1;
        2:       i_rd_ready = ~i_rd_ready;
        default: i_rd_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // driver tasks
  task automatic drive_write(input int addr, input logic [WORD_W-1:0] d, input logic last);
    @(posedge i_clk);
    #1;
    i_we    = 1'b1;
    i_waddr = ADDR_W'(addr);
    i_wdata = d;
    i_wlast = last;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge i_clk);
      #1;
      i_we    = 1'b0;
      i_wlast = 1'b0;
      i_flush = 1'b0;
    end
  endtask

  task automatic write_tile(input int len, input bit use_pat);
    for (int a = 0; a < len; a++)
      drive_write(a, use_pat ? pat(a) : rnd_word(), (a == len - 1));
    idle(1);
  endtask

  task automatic wait_free();
    int k = 0;
    while (full_m[wsel_m] && k < 3000) begin
      @(posedge i_clk);
      #1;
      k++;
    end
    if (k >= 3000) chk("wait_free_timeout", 1, 0);
  endtask

  task automatic wait_drain();
    int k = 0;
    while (exp_q.size() != 0 && k < 3000) begin
      @(posedge i_clk);
      #1;
      k++;
    end
    if (k >= 3000) chk("wait_drain_timeout", 1, 0);
    idle(3);
  endtask

  initial begin
    #2_000_000;
    n_fail++;
    $display("FAIL watchdog expired t=%0t", $time);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    int b0, k;
    logic a_bank;
    i_rst = 1'b1; i_flush = 1'b0; i_we = 1'b0; i_wlast = 1'b0;
    i_waddr = '0; i_wdata = '0;
    repeat (2) @(posedge i_clk);
    #1;
    chk("rst_valid", o_rd_valid, 0);
    chk("rst_bank_full", o_bank_full, 0);
    chk("rst_wfull", o_wfull, 0);
    chk("rst_overflow", o_overflow, 0);
    chk("rst_data", o_rd_data, 0);
    chk("rst_addr", o_rd_addr, 0);
    chk("rst_last", o_rd_last, 0);
    chk("rst_bank", o_rd_bank, 0);
    chk("rst_state", o_rd_state, 0);
    i_rst = 1'b0;
    idle(2);

    // single full tile with pattern data, commit-to-valid latency of two cycles
    rd_mode = 1;
    b0 = beats_seen;
    write_tile(DEPTH, 1'b1);
    @(posedge i_clk); #1;
    chk("t1_lat_not_yet", o_rd_valid, 0);
    @(posedge i_clk); #1;
    chk("t1_lat_valid", o_rd_valid, 1);
    wait_drain();
    chk("t1_beats", beats_seen - b0, DEPTH);
    chk("t1_flags_clear", o_bank_full, 0);

    // short tiles
    b0 = beats_seen;
    wait_free();
    write_tile(10, 1'b0);
    wait_drain();
    chk("t2_beats", beats_seen - b0, 10);
    b0 = beats_seen;
    write_tile(5, 1'b0);
    wait_drain();
    chk("t2_next_beats", beats_seen - b0, 5);

    // both banks full, third write dropped, then drain both
    rd_mode = 0;
    b0 = beats_seen;
    write_tile(DEPTH, 1'b0);
    write_tile(DEPTH, 1'b0);
    drive_write(3, rnd_word(), 1'b0);
    idle(1);
    chk("t3_bank_full", o_bank_full, 2'b11);
    chk("t3_wfull", o_wfull, 1);
    chk("t3_overflow", o_overflow, 1);
    rd_mode = 1;
    wait_drain();
    chk("t3_beats", beats_seen - b0, 2 * DEPTH);

    // backpressure: ready toggles every cycle
    rd_mode = 2;
    b0 = beats_seen;
    write_tile(DEPTH, 1'b0);
    wait_drain();
    chk("t4_beats", beats_seen - b0, DEPTH);

    // commit of one bank on the same edge the other bank releases
    rd_mode = 0;
    b0 = beats_seen;
    wait_free();
    a_bank = wsel_m;
    write_tile(4, 1'b0);
    for (int a = 0; a < 7; a++) drive_write(a, rnd_word(), 1'b0);
    idle(1);
    rd_mode = 1;
    k = 0;
    do begin
      @(negedge i_clk);
      #1;
      k++;
    end while (!(o_rd_valid && i_rd_ready && exp_q.size() == 1) && k < 200);
    if (k >= 200) chk("t5_align_timeout", 1, 0);
    i_we = 1'b1; i_waddr = ADDR_W'(7); i_wdata = rnd_word(); i_wlast = 1'b1;
    @(posedge i_clk); #1;
    i_we = 1'b0; i_wlast = 1'b0;
    @(negedge i_clk); #3;
    chk("t5_flags", o_bank_full, 2'b01 << (~a_bank));
    wait_drain();
    chk("t5_beats", beats_seen - b0, 12);

    // async reset mid-drain
    rd_mode = 1;
    b0 = beats_seen;
    write_tile(DEPTH, 1'b0);
    k = 0;
    do begin
      @(negedge i_clk);
      #1;
      k++;
    end while (!(beats_seen - b0 >= 20 && o_rd_valid) && k < 500);
    if (k >= 500) chk("t6_reach_timeout", 1, 0);
    i_rst = 1'b1;
    #1;
    chk("t6_rst_valid", o_rd_valid, 0);
    chk("t6_rst_flags", o_bank_full, 0);
    chk("t6_rst_overflow", o_overflow, 0);
    chk("t6_rst_state", o_rd_state, 0);
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    idle(2);

    // flush mid-fill with overflow set and write bank 1 selected
    rd_mode = 0;
    write_tile(DEPTH, 1'b0);
    write_tile(DEPTH, 1'b0);
    drive_write(0, rnd_word(), 1'b0);
    idle(1);
    rd_mode = 1;
    wait_drain();
    write_tile(3, 1'b0);
    wait_drain();
    for (int a = 0; a < 10; a++) drive_write(a, rnd_word(), 1'b0);
    idle(1);
    chk("t6_pre_flush_ovf", o_overflow, 1);
    i_flush = 1'b1;
    @(posedge i_clk); #1;
    i_flush = 1'b0;
    chk("t6_flush_ovf", o_overflow, 0);
    chk("t6_flush_flags", o_bank_full, 0);
    chk("t6_flush_bank", o_rd_bank, 0);
    b0 = beats_seen;
    write_tile(12, 1'b0);
    wait_drain();
    chk("t6_flush_beats", beats_seen - b0, 12);

    // randomized tiles with random consumer
    rd_mode = 3;
    for (int t = 0; t < 8; t++) begin
      wait_free();
      write_tile($urandom_range(1, DEPTH), 1'b0);
      idle($urandom_range(0, 5));
    end
    wait_drain();
    chk("rand_queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
